// File: rtl/_reduce_seq_if.sv
// Operand/result handshake bundle for the sequential reduction unit.
// The master side produces operands and consumes results.
interface _reduce_seq_if #(
    parameter int unsigned INPUT_WIDTH = 8
);
    logic                   inputValid;
    logic                   inputReady;
    logic [INPUT_WIDTH-1:0] inputData;
    logic [1:0]             inputMode;
    logic                   outputValid;
    logic                   outputReady;
    logic                   outputData;
    logic                   busy;

    modport master (
        output inputValid, inputData, inputMode, outputReady,
        input  inputReady, outputValid, outputData, busy
    );

    modport slave (
        input  inputValid, inputData, inputMode, outputReady,
        output inputReady, outputValid, outputData, busy
    );
endinterface

// File: rtl/_reduce_seq.sv
// Sequential OR/AND/XOR/XNOR reduction: accepts one operand, folds SLICE_WIDTH bits per
// clock into an accumulator and presents a one-bit result over a valid/ready handshake.
module _reduce_seq #(
    parameter int unsigned INPUT_WIDTH = 8,
    parameter int unsigned SLICE_WIDTH = 2
) (
    input logic       clock,
    input logic       reset,
    input logic [1:0] DigitSupply,
    _reduce_seq_if.slave bus
);
    localparam int unsigned NUM_SLICES = (INPUT_WIDTH + SLICE_WIDTH - 1) / SLICE_WIDTH;
    localparam int unsigned PAD_WIDTH  = NUM_SLICES * SLICE_WIDTH;
    localparam int unsigned IDX_WIDTH  = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_SLICES - 1);

    localparam logic [1:0] ModeOr   = 2'b00;
    localparam logic [1:0] ModeAnd  = 2'b01;
    localparam logic [1:0] ModeXnor = 2'b11;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e                 state_q, state_d;
    logic [PAD_WIDTH-1:0]   data_q, data_d;
    logic [1:0]             mode_q, mode_d;
    logic                   acc_q, acc_d;
    logic                   res_q, res_d;
    logic [IDX_WIDTH-1:0]   idx_q, idx_d;
    logic                   ready_raw;
    logic                   accept;
    logic                   slice_red;
    logic [PAD_WIDTH-1:0]   padded;

    always_comb begin
        ready_raw = (state_q == StIdle) || ((state_q == StDone) && bus.outputReady);
        accept    = bus.inputValid && ready_raw;

        // Pad with the mode identity so the tail bits cannot disturb the result.
        padded = {PAD_WIDTH{bus.inputMode == ModeAnd}};
        padded[INPUT_WIDTH-1:0] = bus.inputData;

        case (mode_q)
            ModeOr:  slice_red = |data_q[SLICE_WIDTH-1:0];
            ModeAnd: slice_red = &data_q[SLICE_WIDTH-1:0];
            default: slice_red = ^data_q[SLICE_WIDTH-1:0];
        endcase

        state_d = state_q;
        data_d  = data_q;
        mode_d  = mode_q;
        acc_d   = acc_q;
        res_d   = res_q;
        idx_d   = idx_q;

        case (state_q)
            StIdle: ;
            StRun: begin
                case (mode_q)
                    ModeOr:  acc_d = acc_q | slice_red;
                    ModeAnd: acc_d = acc_q & slice_red;
                    default: acc_d = acc_q ^ slice_red;
                endcase
                data_d = data_q >> SLICE_WIDTH;
                idx_d  = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = StDone;
                    res_d   = (mode_q == ModeXnor) ? ~acc_d : acc_d;
                end
            end
            StDone: begin
                if (bus.outputReady) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Accept is only possible from IDLE or a completing DONE; both lead to RUN.
        if (accept) begin
            state_d = StRun;
            data_d  = padded;
            mode_d  = bus.inputMode;
            acc_d   = (bus.inputMode == ModeAnd);
            idx_d   = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            data_q  <= '0;
            mode_q  <= ModeOr;
            acc_q   <= 1'b0;
            res_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            mode_q  <= mode_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            idx_q   <= idx_d;
        end
    end

    assign bus.inputReady  = (ready_raw && !reset) ? DigitSupply[1] : DigitSupply[0];
    assign bus.outputValid = (state_q == StDone)   ? DigitSupply[1] : DigitSupply[0];
    assign bus.outputData  = res_q                 ? DigitSupply[1] : DigitSupply[0];
    assign bus.busy        = (state_q == StRun)    ? DigitSupply[1] : DigitSupply[0];
endmodule

// File: tb/tb__reduce_seq.sv
// Directed bench for _reduce_seq: an 8/2 instance for the main checks and a 7/3 instance
// exercising last-slice padding.
module tb__reduce_seq;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] digit_supply = 2'b10;
    int         n_vec = 0;
    int         n_err = 0;

    _reduce_seq_if #(.INPUT_WIDTH(8)) ba ();
    _reduce_seq_if #(.INPUT_WIDTH(7)) bb ();

    _reduce_seq #(.INPUT_WIDTH(8), .SLICE_WIDTH(2)) dut_a (
        .clock       (clock),
        .reset       (reset),
        .DigitSupply (digit_supply),
        .bus         (ba)
    );

    _reduce_seq #(.INPUT_WIDTH(7), .SLICE_WIDTH(3)) dut_b (
        .clock       (clock),
        .reset       (reset),
        .DigitSupply (digit_supply),
        .bus         (bb)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One operation on the 8/2 unit; inputs are scrambled during RUN to prove capture.
    task automatic op_a(input logic [1:0] m, input logic [7:0] d, input logic exp,
                        input string tag);
        int lat;
        int nb;
        ba.inputMode   = m;
        ba.inputData   = d;
        ba.inputValid  = 1'b1;
        ba.outputReady = 1'b0;
        #1;
        chk({tag, " ready"}, ba.inputReady, 1);
        tick();
        ba.inputValid = 1'b0;
        ba.inputData  = ~d;
        ba.inputMode  = m ^ 2'b11;
        lat = 1;
        nb  = 0;
        while (ba.outputValid !== 1'b1 && lat < 20) begin
            if (ba.busy === 1'b1) nb++;
            tick();
            lat++;
        end
        chk({tag, " latency"}, lat, 5);
        chk({tag, " busy"}, nb, 4);
        chk({tag, " result"}, ba.outputData, exp);
        ba.outputReady = 1'b1;
        tick();
        ba.outputReady = 1'b0;
        chk({tag, " valid drop"}, ba.outputValid, 0);
    endtask

    task automatic op_b(input logic [1:0] m, input logic [6:0] d, input logic exp,
                        input string tag);
        int lat;
        bb.inputMode   = m;
        bb.inputData   = d;
        bb.inputValid  = 1'b1;
        bb.outputReady = 1'b0;
        tick();
        bb.inputValid = 1'b0;
        lat = 1;
        while (bb.outputValid !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        chk({tag, " latency"}, lat, 4);
        chk({tag, " result"}, bb.outputData, exp);
        bb.outputReady = 1'b1;
        tick();
        bb.outputReady = 1'b0;
    endtask

    initial begin
        int lat;
        ba.inputValid = 1'b0; ba.inputData = '0; ba.inputMode = 2'b00; ba.outputReady = 1'b0;
        bb.inputValid = 1'b0; bb.inputData = '0; bb.inputMode = 2'b00; bb.outputReady = 1'b0;

        // Reset behaviour
        tick();
        tick();
        chk("rst inputReady", ba.inputReady, 0);
        chk("rst outputValid", ba.outputValid, 0);
        chk("rst outputData", ba.outputData, 0);
        chk("rst busy", ba.busy, 0);
        reset = 1'b0;
        #1;
        chk("post-rst inputReady", ba.inputReady, 1);
        tick();

        // Basic OR and the other modes
        op_a(2'b00, 8'h00, 1'b0, "OR 00");
        op_a(2'b00, 8'h10, 1'b1, "OR 10");
        op_a(2'b01, 8'hFF, 1'b1, "AND FF");
        op_a(2'b01, 8'hFE, 1'b0, "AND FE");
        op_a(2'b10, 8'h07, 1'b1, "XOR 07");
        op_a(2'b11, 8'h07, 1'b0, "XNOR 07");
        op_a(2'b11, 8'h00, 1'b1, "XNOR 00");

        // Back-pressure: hold DONE for 10 cycles, then a single transfer
        ba.inputMode = 2'b00; ba.inputData = 8'h10; ba.inputValid = 1'b1;
        tick();
        lat = 1;
        while (ba.outputValid !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        chk("bp latency", lat, 5);
        for (int i = 0; i < 10; i++) begin
            chk("bp valid", ba.outputValid, 1);
            chk("bp data", ba.outputData, 1);
            chk("bp inputReady", ba.inputReady, 0);
            tick();
        end
        ba.inputValid  = 1'b0;
        ba.outputReady = 1'b1;
        tick();
        ba.outputReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("bp single transfer", ba.outputValid, 0);
            chk("bp idle", ba.busy, 0);
            tick();
        end

        // Back-to-back: OR 01 then OR 00 with valid/ready held high
        ba.inputMode = 2'b00; ba.inputData = 8'h01;
        ba.inputValid = 1'b1; ba.outputReady = 1'b1;
        tick();
        ba.inputData = 8'h00;
        lat = 1;
        while (ba.outputValid !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        chk("b2b first latency", lat, 5);
        chk("b2b first result", ba.outputData, 1);
        chk("b2b overlap ready", ba.inputReady, 1);
        tick();
        ba.inputValid = 1'b0;
        chk("b2b no bubble busy", ba.busy, 1);
        chk("b2b valid drop", ba.outputValid, 0);
        lat = 1;
        while (ba.outputValid !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        chk("b2b second latency", lat, 5);
        chk("b2b second result", ba.outputData, 0);
        tick();
        ba.outputReady = 1'b0;
        chk("b2b end idle", ba.outputValid, 0);

        // Leave a 1 in the result register, then abort an operation with reset
        op_a(2'b00, 8'h10, 1'b1, "pre-rst OR 10");
        ba.inputMode = 2'b00; ba.inputData = 8'hFF; ba.inputValid = 1'b1;
        tick();
        ba.inputValid = 1'b0;
        tick();
        chk("abort in RUN", ba.busy, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("abort busy", ba.busy, 0);
        chk("abort outputValid", ba.outputValid, 0);
        chk("abort outputData", ba.outputData, 0);
        chk("abort inputReady", ba.inputReady, 1);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("abort no stale", ba.outputValid, 0);
        end
        op_a(2'b01, 8'hFF, 1'b1, "post-rst AND FF");

        // Padding on the 7/3 unit
        op_b(2'b01, 7'h7F, 1'b1, "pad AND 7F");
        op_b(2'b00, 7'h40, 1'b1, "pad OR 40");
        op_b(2'b10, 7'h41, 1'b0, "pad XOR 41");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/_reduce_seq.md
# _reduce_seq

Sequential, multi-mode reduction unit: the next generation of the parametrised OR chain. It captures an INPUT_WIDTH-bit word through a valid/ready handshake and reduces it SLICE_WIDTH bits per clock using a selectable OR/AND/XOR/XNOR operator. It returns a one-bit result through a second valid/ready handshake. It sits between operand producers and flag/compare logic where a full-width combinational chain is too deep for one cycle.

## Interface

- INPUT_WIDTH, 8: operand width in bits, ≥1.
- SLICE_WIDTH, 2: bits reduced per clock, 1..INPUT_WIDTH.
- NUM_SLICES (localparam): ceil(INPUT_WIDTH/SLICE_WIDTH).

- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- DigitSupply  in  2  logic rails: [0] is the logic-0 level and [1] is the logic-1 level. Nominal value is 2'b10.
- inputValid  in  1  operand and mode are presented.
- inputReady  out  1  unit can accept an operand this cycle.
- inputData  in  INPUT_WIDTH  operand.
- inputMode  in  2  operator: 00 OR, 01 AND, 10 XOR, 11 XNOR.
- outputValid  out  1  outputData holds a result.
- outputReady  in  1  consumer takes the result this cycle.
- outputData  out  1  reduction result.
- busy  out  1  state is RUN.

## Operation

- All outputs are driven from the rails. A logic 1 is driven as DigitSupply[1] and a logic 0 as DigitSupply[0].
- States and transitions:
  - IDLE: inputReady=1. Moves to RUN on accept.
  - RUN: reduces one slice per cycle. Moves to DONE after slice NUM_SLICES-1.
  - DONE: outputValid=1. Moves on outputReady.
- Accept = inputValid && inputReady.
  - On accept, inputData and inputMode are registered. Later changes on the inputs have no effect.
  - On accept, the slice index is set to 0.
  - On accept, the accumulator is set to the mode identity: 0 for OR/XOR/XNOR, 1 for AND.
- Each RUN cycle:
  - accumulator ← accumulator op (reduction of slice k).
  - Slice k covers bits [k·SLICE_WIDTH +: SLICE_WIDTH].
  - Bits at or beyond INPUT_WIDTH in the last slice are padded with the mode identity, so padding never changes the result.
- Entering DONE, the result is registered:
  - accumulator for OR/AND/XOR;
  - inverted accumulator for XNOR.
  - outputData holds this value for the whole DONE state.
- Leaving DONE when outputReady=1:
  - If inputValid=1 in the same cycle, the new operand is accepted and the state goes directly to RUN. inputReady = (state==IDLE) || (state==DONE && outputReady).
  - Otherwise the state goes to IDLE.
- Reset: state ← IDLE, accumulator ← 0, slice index ← 0. Reset mid-RUN or mid-DONE aborts the operation; the result is discarded and no outputValid pulse is produced.
- Reset values: inputReady=0 during reset, 1 in the first cycle after; outputValid=0; outputData=0 (DigitSupply[0]); busy=0.

## Timing

- Accept at clock edge E. RUN occupies the NUM_SLICES cycles after E. outputValid first rises after edge E+NUM_SLICES.
- Latency from the accept cycle to the first outputValid cycle is NUM_SLICES+1 cycles. SLICE_WIDTH=INPUT_WIDTH gives a 1-cycle RUN.
- Throughput with outputReady held at 1: one result per NUM_SLICES+1 cycles. Back-to-back operation has no idle bubble.
- Back-pressure: DONE, outputValid and outputData are held indefinitely while outputReady=0. inputReady stays 0 for this period.
- inputReady and outputValid are purely state-decoded, except for the outputReady term in inputReady. There is no combinational path from inputValid to any output.
- The critical path is one SLICE_WIDTH-input reduction plus the accumulator operator.

## Test plan

- Basic OR, defaults (8/2):
  - 8'h00 → 0; 8'h10 → 1.
  - outputValid rises exactly 5 cycles after the accept cycle; busy is high for 4 cycles.
- Modes:
  - AND 8'hFF → 1; AND 8'hFE → 0.
  - XOR 8'h07 → 1; XNOR 8'h07 → 0; XNOR 8'h00 → 1.
  - inputData and inputMode are changed during RUN; the result must not change.
- Padding (INPUT_WIDTH=7, SLICE_WIDTH=3, NUM_SLICES=3):
  - AND 7'h7F → 1; OR 7'h40 → 1; XOR 7'h41 → 0.
  - Latency is 4 cycles.
- Back-pressure: hold outputReady=0 for 10 cycles in DONE → outputValid/outputData stable and inputReady=0; release → one transfer only.
- Back-to-back:
  - inputValid and outputReady are held high with OR operands 8'h01 then 8'h00.
  - Required results are 1 then 0, with the second accept in the same cycle as the first output transfer.
- Reset:
  - Assert reset in the 2nd RUN cycle → next cycle shows IDLE, outputValid=0, outputData=0, inputReady=1.
  - No stale result appears. The next operation (AND 8'hFF) returns 1 with normal latency.
